// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ready/valid data-memory port, store lane alignment,
// load extension, upstream stall generation and the M->W pipeline register.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  RegWriteM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [1:0]            ResultSrcM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e state_q, state_d;

  logic [1:0]            a;
  logic                  access, is_half, is_word, misalign, aligned_access;
  logic                  req_raw, complete;
  logic [DATA_WIDTH-1:0] byte_shift, half_shift, load_ext;

  assign a              = ALUResultM[1:0];
  assign access         = MemReadM | MemWriteM;
  assign is_half        = (Funct3M[1:0] == 2'b01);
  assign is_word        = Funct3M[1];
  assign misalign       = access && ((is_half && a[0]) || (is_word && (a != 2'b00)));
  assign aligned_access = access && !misalign;

  // Request and completion decode; misaligned accesses never leave StIdle.
  always_comb begin
    state_d  = state_q;
    req_raw  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle, StReq: begin
        req_raw = (state_q == StReq) || aligned_access;
        if (req_raw) begin
          if (mem_ready) begin
            if (MemWriteM || mem_rvalid) begin
              complete = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = StReq;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req   = req_raw && !rst;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign StallM    = access && !(complete || misalign) && !rst;
  assign MisalignM = misalign && !rst;

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (Funct3M[1:0] == 2'b00) begin
      mem_be    = 4'b0001 << a;
      mem_wdata = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      mem_be    = 4'b0011 << {a[1], 1'b0};
      mem_wdata = {2{WriteDataM[15:0]}};
    end
  end

  assign byte_shift = mem_rdata >> {a, 3'b000};
  assign half_shift = mem_rdata >> {a[1], 4'b0000};

  always_comb begin
    unique case (Funct3M)
      3'b000:  load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_ext = {24'h0, byte_shift[7:0]};
      3'b101:  load_ext = {16'h0, half_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      state_q <= state_d;
      if (StallM) begin
        ALUResultW <= '0;
        ReadDataW  <= '0;
        PCPlus4W   <= '0;
        RdW        <= '0;
        RegWriteW  <= 1'b0;
        ResultSrcW <= '0;
      end else begin
        ALUResultW <= ALUResultM;
        ReadDataW  <= MemReadM ? load_ext : '0;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        RegWriteW  <= RegWriteM && !misalign;
        ResultSrcW <= ResultSrcM;
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage controller that consumes the execute-to-memory pipeline register outputs. It performs loads and stores against a variable-latency data memory over a ready/valid handshake and stalls the upstream pipeline while an access is outstanding. It drives byte enables, aligns store data, and sign- or zero-extends load data. It also contains the memory-to-writeback pipeline register, so it sits between the execute-to-memory register and the writeback mux.

## Interface
- DATA_WIDTH, 32, datapath width (byte-lane logic fixed at 4 lanes)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ALUResultM  in  DATA_WIDTH  effective address / ALU result
- WriteDataM  in  DATA_WIDTH  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  DATA_WIDTH  return address
- RegWriteM, MemReadM, MemWriteM  in  1 each  control; MemReadM and MemWriteM never both 1
- Funct3M  in  3  access size/sign
- ResultSrcM  in  2  writeback select, passed through
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_addr  out  DATA_WIDTH  word-aligned address ({ALUResultM[31:2],2'b00})
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts request
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DATA_WIDTH  load word
- StallM  out  1  hold fetch/decode/execute and the E->M register
- MisalignM  out  1  one-cycle pulse on a misaligned access
- ALUResultW, ReadDataW, PCPlus4W  out  DATA_WIDTH  writeback operands
- RdW  out  5; RegWriteW  out  1; ResultSrcW  out  2

## Operation
- Access = MemReadM|MemWriteM. Non-access instructions pass to W with 1-cycle latency and no stall.
- FSM states: IDLE, REQ, WAIT.
  - IDLE with an aligned access: mem_req=1 combinationally.
    - Accepted (mem_ready=1): a store completes; a load completes if mem_rvalid=1 in the same cycle, else goes to WAIT.
    - Not accepted: go to REQ.
  - REQ: mem_req=1 until mem_ready, then behaves as IDLE acceptance.
  - WAIT: mem_req=0; when mem_rvalid=1, the load completes and the FSM returns to IDLE.
- StallM = Access && !(completes this cycle). Upstream holds its inputs stable while StallM=1.
- W register:
  - While StallM=1 it loads a bubble (RegWriteW=0, other fields don't-care but deterministic 0).
  - On completion or a non-access cycle it captures the M fields; ReadDataW takes the extended load data.
- Store lanes, with a = ALUResultM[1:0]:
  - SB (000): be=0001<<a, wdata={4{byte}}
  - SH (001): be=0011<<{a[1],0}, wdata={2{half}}
  - SW (010): be=1111
- Load extension selects the byte/half by a:
  - LB 000 sign, LH 001 sign, LW 010, LBU 100 zero, LHU 101 zero.
  - Funct3 011/110/111 are treated as LW.
- Misaligned (half with a[0]=1, word with a!=0):
  - No request issued; completes in one cycle with no stall.
  - RegWriteW=0 and MisalignM=1 for that cycle.
- mem_rvalid outside WAIT (and outside a same-cycle accept) is ignored.

## Timing
- Reset values: state IDLE, all W outputs 0, StallM 0, MisalignM 0. mem_req is forced to 0 while rst=1.
- Reset mid-access (REQ/WAIT): return to IDLE immediately and abandon the access. A later stray mem_rvalid is ignored.
- Store with mem_ready=1: 0 stall cycles; W valid the next edge.
- Load, ready=1, rvalid N cycles after accept: N stall cycles; W captures on the edge of the rvalid cycle.
- mem_addr/mem_we/mem_be/mem_wdata are stable for as long as mem_req=1 (inputs held by StallM).
- Back-to-back accesses: the next access may request in the cycle after completion. No idle gap is required.

## Test plan
- ALU op: ALUResultM=0x10, RdM=5, RegWriteM=1 -> next edge ALUResultW=0x10, RdW=5, RegWriteW=1, StallM never 1.
- SB to 0x1003, WriteDataM=0xAB, mem_ready=1 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, no stall.
- LB from 0x2001, mem_ready=1, rvalid 2 cycles later with rdata=0x0000_8000 -> StallM high 2 cycles, RegWriteW=0 during the stall, then ReadDataW=0xFFFF_FF80. The same case with LBU gives 0x0000_0080.
- SW with mem_ready low 3 cycles -> mem_req held 4 cycles with stable address/data, StallM high 3 cycles.
- LW at 0x3002 -> mem_req stays 0, MisalignM pulses 1 cycle, RegWriteW=0, no stall.
- rst asserted in WAIT, then rvalid pulses after release -> state IDLE, W outputs 0, rvalid ignored.
